// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note-to-voice allocator with release reuse and oldest-voice stealing
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = 7,
  parameter int AGE_BITS   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]           env_idle,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES-1:0]           trig,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            busy
);

  localparam int IDX_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  localparam logic [1:0] V_FREE = 2'd0;
  localparam logic [1:0] V_HELD = 2'd1;
  localparam logic [1:0] V_REL  = 2'd2;

  localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NUM_VOICES - 1);

  logic [1:0]           fsm;
  logic [IDX_BITS-1:0]  scan_idx;
  logic                 lat_on;
  logic [NOTE_BITS-1:0] lat_note;

  logic [1:0]           vstate [NUM_VOICES];
  logic [AGE_BITS-1:0]  age    [NUM_VOICES];
  logic [NOTE_BITS-1:0] note_r [NUM_VOICES];

  logic                 free_found, rel_found, held_found, match_found;
  logic [IDX_BITS-1:0]  free_idx, rel_idx, held_idx, match_idx, tgt_idx;
  logic [AGE_BITS-1:0]  rel_age, held_age;

  assign ev_ready = (fsm == ST_IDLE) && !reset;
  assign busy     = !ev_ready;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign gate[g] = (vstate[g] == V_HELD);
    assign voice_note[g*NOTE_BITS +: NOTE_BITS] = note_r[g];
  end

  // Note-on target priority: retrigger, free, oldest releasing, oldest held.
  always_comb begin
    tgt_idx = held_idx;
    if (match_found)     tgt_idx = match_idx;
    else if (free_found) tgt_idx = free_idx;
    else if (rel_found)  tgt_idx = rel_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= ST_IDLE;
      scan_idx    <= '0;
      lat_on      <= 1'b0;
      lat_note    <= '0;
      trig        <= '0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
      held_found  <= 1'b0;
      match_found <= 1'b0;
      free_idx    <= '0;
      rel_idx     <= '0;
      held_idx    <= '0;
      match_idx   <= '0;
      rel_age     <= '0;
      held_age    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate[i] <= V_FREE;
        age[i]    <= '0;
        note_r[i] <= '0;
      end
    end else begin
      trig <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (vstate[i] == V_REL && env_idle[i]) vstate[i] <= V_FREE;
      end

      case (fsm)
        ST_IDLE: begin
          if (ev_valid) begin
            lat_on      <= ev_on;
            lat_note    <= ev_note;
            scan_idx    <= '0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            held_found  <= 1'b0;
            match_found <= 1'b0;
            fsm         <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          // Strict greater-than keeps the lowest index on equal ages.
          case (vstate[scan_idx])
            V_FREE: begin
              if (!free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
              end
            end
            V_REL: begin
              if (!rel_found || age[scan_idx] > rel_age) begin
                rel_found <= 1'b1;
                rel_idx   <= scan_idx;
                rel_age   <= age[scan_idx];
              end
            end
            V_HELD: begin
              if (!held_found || age[scan_idx] > held_age) begin
                held_found <= 1'b1;
                held_idx   <= scan_idx;
                held_age   <= age[scan_idx];
              end
              if (!match_found && note_r[scan_idx] == lat_note) begin
                match_found <= 1'b1;
                match_idx   <= scan_idx;
              end
            end
            default: ;
          endcase
          if (scan_idx == IDX_LAST) fsm <= ST_APPLY;
          else                      scan_idx <= scan_idx + IDX_BITS'(1);
        end

        ST_APPLY: begin
          // These writes come after the env_idle freeing above, so they win.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (lat_on) begin
              if (IDX_BITS'(i) == tgt_idx) begin
                vstate[i] <= V_HELD;
                age[i]    <= '0;
                note_r[i] <= lat_note;
                trig[i]   <= 1'b1;
              end else if (vstate[i] != V_FREE && age[i] != AGE_MAX) begin
                age[i] <= age[i] + AGE_BITS'(1);
              end
            end else if (vstate[i] == V_HELD && note_r[i] == lat_note) begin
              vstate[i] <= V_REL;
            end
          end
          fsm <= ST_IDLE;
        end

        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [3:0]  env_idle;
  logic [3:0]  gate;
  logic [3:0]  trig;
  logic [27:0] voice_note;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(4), .NOTE_BITS(7), .AGE_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_note    (ev_note),
    .env_idle   (env_idle),
    .gate       (gate),
    .trig       (trig),
    .voice_note (voice_note),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] notes(input logic [6:0] n3, input logic [6:0] n2,
                                        input logic [6:0] n1, input logic [6:0] n0);
    return {n3, n2, n1, n0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Accept at edge E0; APPLY occupies the cycle after E4; results appear after E5.
  task automatic send(input logic on, input logic [6:0] note, input logic [3:0] exp_trig);
    int n;
    @(negedge clk);
    n = 0;
    while (!ev_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, ev_ready}, 32'd1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ready_in_apply", {31'd0, ev_ready}, 32'd0);
    chk("trig_in_apply", {28'd0, trig}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after", {31'd0, ev_ready}, 32'd1);
    chk("trig_after", {28'd0, trig}, {28'd0, exp_trig});
    @(posedge clk);
    #1;
    chk("trig_clear", {28'd0, trig}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_note  = '0;
    env_idle = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gate", {28'd0, gate}, 32'd0);
    chk("rst_trig", {28'd0, trig}, 32'd0);
    chk("rst_notes", {4'd0, voice_note}, 32'd0);
    chk("rst_ready", {31'd0, ev_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_post_rst", {31'd0, ev_ready}, 32'd1);

    // basic note-on and retrigger of the same note
    send(1'b1, 7'd60, 4'b0001);
    chk("basic_gate", {28'd0, gate}, 32'h1);
    chk("basic_notes", {4'd0, voice_note}, {4'd0, notes(0, 0, 0, 60)});
    send(1'b1, 7'd60, 4'b0001);
    chk("retrig_gate", {28'd0, gate}, 32'h1);
    chk("retrig_notes", {4'd0, voice_note}, {4'd0, notes(0, 0, 0, 60)});

    // fill, release, free via env_idle, reuse
    do_reset();
    send(1'b1, 7'd60, 4'b0001);
    send(1'b1, 7'd62, 4'b0010);
    send(1'b1, 7'd64, 4'b0100);
    send(1'b0, 7'd62, 4'b0000);
    chk("release_gate", {28'd0, gate}, 32'h5);
    send(1'b0, 7'd99, 4'b0000);
    chk("nomatch_off_gate", {28'd0, gate}, 32'h5);
    @(negedge clk) env_idle = 4'b0010;
    @(negedge clk) env_idle = 4'b0000;
    send(1'b1, 7'd67, 4'b0010);
    chk("reuse_gate", {28'd0, gate}, 32'h7);
    chk("reuse_notes", {4'd0, voice_note}, {4'd0, notes(0, 64, 67, 60)});

    // steal the oldest held voice; env_idle on held voices is ignored
    do_reset();
    send(1'b1, 7'd60, 4'b0001);
    send(1'b1, 7'd62, 4'b0010);
    send(1'b1, 7'd64, 4'b0100);
    send(1'b1, 7'd65, 4'b1000);
    @(negedge clk) env_idle = 4'b1111;
    @(negedge clk) env_idle = 4'b1111;
    @(negedge clk) env_idle = 4'b0000;
    chk("held_ignore_idle", {28'd0, gate}, 32'hF);
    send(1'b1, 7'd67, 4'b0001);
    chk("steal_gate", {28'd0, gate}, 32'hF);
    chk("steal_notes", {4'd0, voice_note}, {4'd0, notes(65, 64, 62, 67)});

    // releasing voice preferred over older held voice
    send(1'b0, 7'd64, 4'b0000);
    chk("relpref_off_gate", {28'd0, gate}, 32'hB);
    send(1'b1, 7'd70, 4'b0100);
    chk("relpref_gate", {28'd0, gate}, 32'hF);
    chk("relpref_notes", {4'd0, voice_note}, {4'd0, notes(65, 70, 62, 67)});

    // reset during SCAN
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_note  = 7'd33;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_gate", {28'd0, gate}, 32'd0);
    chk("midrst_trig", {28'd0, trig}, 32'd0);
    chk("midrst_notes", {4'd0, voice_note}, 32'd0);
    chk("midrst_ready", {31'd0, ev_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("midrst_ready_after", {31'd0, ev_ready}, 32'd1);
    send(1'b1, 7'd50, 4'b0001);
    chk("fresh_gate", {28'd0, gate}, 32'h1);
    chk("fresh_notes", {4'd0, voice_note}, {4'd0, notes(0, 0, 0, 50)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
